// File: rtl/seven_seg_scanner.sv
// Time-multiplexed four-digit display scanner with a blanking gap before each
// digit, frame-synchronous value updates and optional leading-zero suppression.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        lz_en,
    output logic [3:0]  digit_code,
    output logic [1:0]  digit_sel,
    output logic [3:0]  anode,
    output logic        frame_done,
    output logic        state_dbg
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sel_n;
    logic          wrap;

    logic [15:0]   shadow, shadow_n;
    logic [15:0]   pending, pending_n;
    logic          pend_valid, pend_valid_n;

    logic [3:0]    anode_n;
    logic [3:0]    code_n;
    logic [3:0]    upper_zero;

    assign state_dbg = (state == SHOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            cnt       <= '0;
            digit_sel <= 2'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            digit_sel <= sel_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        sel_n   = digit_sel;
        wrap    = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end
            end
            SHOW: begin
                if (cnt == CW'(REFRESH_DIV - 1)) begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    sel_n   = digit_sel + 2'd1;
                    wrap    = (digit_sel == 2'd3);
                end
            end
            default: begin
                state_n = BLANK;
                cnt_n   = '0;
            end
        endcase
    end

    // A load on the wrap cycle bypasses pending so the new frame shows it at once.
    always_comb begin
        shadow_n     = shadow;
        pending_n    = pending;
        pend_valid_n = pend_valid;
        if (load && wrap) begin
            shadow_n     = value_in;
            pend_valid_n = 1'b0;
        end else if (load) begin
            pending_n    = value_in;
            pend_valid_n = 1'b1;
        end else if (wrap && pend_valid) begin
            shadow_n     = pending;
            pend_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else begin
            shadow     <= shadow_n;
            pending    <= pending_n;
            pend_valid <= pend_valid_n;
        end
    end

    // Outputs are precomputed from next-state values so they line up with digit_sel.
    always_comb begin
        upper_zero[0] = 1'b0;
        upper_zero[1] = (shadow_n[15:4] == 12'h000);
        upper_zero[2] = (shadow_n[15:8] == 8'h00);
        upper_zero[3] = (shadow_n[15:12] == 4'h0);
        anode_n = 4'b1111;
        if (state_n == SHOW && !(lz_en && upper_zero[sel_n]))
            anode_n = ~(4'b0001 << sel_n);
        code_n = shadow_n[{sel_n, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode      <= 4'b1111;
            digit_code <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            anode      <= anode_n;
            digit_code <= code_n;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a time-based frame model predicts every output
// cycle by cycle for directed and randomized load / lz_en stimulus.
module tb_seven_seg_scanner;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  digit_code;
    logic [1:0]  digit_sel;
    logic [3:0]  anode;
    logic        frame_done;
    logic        state_dbg;

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .lz_en(lz_en),
        .digit_code(digit_code), .digit_sel(digit_sel), .anode(anode),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: k = cycles since reset release; the frame position follows from k alone.
    int          k;
    logic [15:0] m_shadow, m_pend;
    logic        m_pv, m_lz;

    wire [10:0] obs = {anode, digit_sel, digit_code, frame_done};

    function automatic logic [10:0] exp_vec();
        int p, d;
        logic show, supp;
        logic [15:0] upper;
        logic [3:0] an, code;
        p     = k % FRAME;
        d     = p / SLOT;
        show  = (p % SLOT) >= BC;
        upper = m_shadow >> (4 * d);
        code  = upper[3:0];
        supp  = m_lz && (d > 0) && (upper == 16'h0);
        an    = (show && !supp) ? ~(4'b0001 << d) : 4'b1111;
        return {an, 2'(d), code, (k > 0) && (p == 0)};
    endfunction

    task automatic model_reset();
        k = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0; m_lz = 1'b0;
    endtask

    task automatic tick(input logic l, input logic [15:0] v, input logic z);
        logic wrap;
        load = l; value_in = v; lz_en = z;
        @(posedge clk);
        wrap = (k % FRAME) == FRAME - 1;
        if (l) begin
            if (wrap) begin m_shadow = v; m_pv = 1'b0; end
            else begin m_pend = v; m_pv = 1'b1; end
        end else if (wrap && m_pv) begin
            m_shadow = m_pend; m_pv = 1'b0;
        end
        m_lz = z;
        k++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; lz_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 11'b1111_00_0000_0) begin
            errors++; $display("FAIL reset_hold got %h exp %h", obs, 11'b1111_00_0000_0);
        end
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_release got %h exp %h", obs, exp_vec());
        end
    endtask

    task automatic test_idle_scan();
        int fd_count = 0;
        repeat (2 * FRAME) begin
            tick(1'b0, 16'h0, 1'b0);
            fd_count += int'(frame_done);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL idle_scan k=%0d got %h exp %h", k, obs, exp_vec());
            end
        end
        checks++;
        if (fd_count != 2) begin
            errors++; $display("FAIL idle_frame_done_count got %0d exp 2", fd_count);
        end
    endtask

    task automatic test_load_midframe();
        while ((k % FRAME) != 15) tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h1234, 1'b0);
        repeat (2 * FRAME) begin
            tick(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL load_midframe k=%0d got %h exp %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_overwrite();
        while ((k % FRAME) != 5) tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'hAAAA, 1'b0);
        repeat (10) tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h5555, 1'b0);
        repeat (FRAME + 10) begin
            tick(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL overwrite k=%0d got %h exp %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_load_on_wrap();
        while ((k % FRAME) != 20) tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h1111, 1'b0);
        while ((k % FRAME) != FRAME - 1) tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h00F7, 1'b0);
        checks++;
        if (digit_code !== 4'h7 || digit_sel !== 2'd0) begin
            errors++; $display("FAIL wrap_load_immediate got code %h sel %0d exp 7 0", digit_code, digit_sel);
        end
        repeat (2 * FRAME) begin
            tick(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL load_on_wrap k=%0d got %h exp %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2] = '{16'h0005, 16'h0000};
        foreach (vals[i]) begin
            tick(1'b1, vals[i], 1'b1);
            repeat (2 * FRAME) begin
                tick(1'b0, 16'h0, 1'b1);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL lz_%h k=%0d got %h exp %h", vals[i], k, obs, exp_vec());
                end
            end
        end
        // lz_en dropped mid-SHOW of a suppressed digit must relight it next cycle
        while ((k % FRAME) != SLOT + BC + 2) tick(1'b0, 16'h0, 1'b1);
        tick(1'b0, 16'h0, 1'b0);
        checks++;
        if (anode !== 4'b1101) begin
            errors++; $display("FAIL lz_toggle got %b exp 1101", anode);
        end
    endtask

    task automatic test_random();
        logic z = 1'b0;
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) z = ~z;
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] v;
                v = 16'($urandom);
                if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 4));
                tick(1'b1, v, z);
            end else begin
                tick(1'b0, 16'h0, z);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random k=%0d got %h exp %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        while ((k % FRAME) != SLOT + BC + 1) tick(1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h9876, 1'b0);
        while ((k % FRAME) != 2 * SLOT + BC + 3) tick(1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({anode, digit_sel, frame_done} !== 7'b1111_00_0) begin
            errors++; $display("FAIL reset_mid_async got anode %b sel %0d exp 1111 0", anode, digit_sel);
        end
        checks++;
        if (digit_code !== 4'h0) begin
            errors++; $display("FAIL reset_mid_code got %h exp 0", digit_code);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_release got %h exp %h", obs, exp_vec());
        end
        repeat (2 * FRAME + 5) begin
            tick(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset_mid_restart k=%0d got %h exp %h", k, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_scan();
        test_load_midframe();
        test_overwrite();
        test_load_on_wrap();
        test_lz();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 1000: SHALL set the clock cycles each digit is lit per visit; legal range >= 2.
REQ-002 Parameter BLANK_CYCLES, default 4: SHALL set the all-anodes-off cycles before each digit is lit; legal range >= 1.
REQ-003 clk  input  1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: SHALL be the asynchronous, active-low reset.
REQ-005 load  input  1: SHALL request capture of value_in when high for one cycle.
REQ-006 value_in  input  16: SHALL carry four BCD/hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 lz_en  input  1: SHALL enable leading-zero suppression when high.
REQ-008 digit_code  output  4: SHALL be the nibble for the currently selected digit, feeding the downstream 7-segment decoder.
REQ-009 digit_sel  output  2: SHALL be the index 0..3 of the currently selected digit.
REQ-010 anode  output  4: SHALL be the active-low digit enables; bit n drives digit n.
REQ-011 frame_done  output  1: SHALL be a one-cycle pulse at each 3->0 digit wrap.

Function
REQ-012 The block SHALL hold a 16-bit display (shadow) register and a 16-bit pending register with a pending_valid flag.
REQ-013 A load cycle SHALL write value_in to pending and set pending_valid; a later load before the wrap SHALL overwrite pending.
REQ-014 At the wrap cycle, if pending_valid is set, the block SHALL copy pending to shadow and clear pending_valid. This prevents mid-frame tearing.
REQ-015 If load and the wrap coincide, the block SHALL write value_in directly to shadow and leave pending_valid clear.
REQ-016 FSM states SHALL be BLANK and SHOW, with one cycle counter of width clog2(max(REFRESH_DIV, BLANK_CYCLES)).
REQ-017 BLANK SHALL last exactly BLANK_CYCLES cycles with anode = 4'b1111, then go to SHOW with the counter at 0.
REQ-018 SHOW SHALL last exactly REFRESH_DIV cycles with anode = ~(1 << digit_sel), unless suppressed by REQ-020.
REQ-019 At the end of SHOW, the block SHALL increment digit_sel modulo 4 and enter BLANK. The 3->0 transition is the wrap cycle.
REQ-020 With lz_en = 1, a digit n > 0 whose nibble and all higher nibbles in shadow are zero SHALL keep anode high during SHOW. Digit 0 SHALL never be suppressed.
REQ-021 digit_code SHALL equal shadow[4*digit_sel +: 4] in both states and SHALL be registered, changing in the same cycle digit_sel changes.
REQ-022 All outputs SHALL be registered. The full frame period SHALL be 4*(REFRESH_DIV + BLANK_CYCLES) cycles.
REQ-023 frame_done SHALL assert on the first cycle in which digit_sel = 0 after a wrap, and SHALL NOT assert after reset.
REQ-024 lz_en changes SHALL take effect on the next cycle's anode value.

Reset
REQ-025 While rst_n = 0, the block SHALL asynchronously force: state BLANK, counter 0, digit_sel 0, digit_code 0, anode 4'b1111, frame_done 0, shadow 0, pending 0, pending_valid 0.
REQ-026 On rst_n deassertion, the block SHALL start a full BLANK_CYCLES blanking interval for digit 0.
REQ-027 Reset asserted mid-SHOW or mid-BLANK SHALL abandon the frame; the pending value SHALL be lost.

Verification (REFRESH_DIV = 8, BLANK_CYCLES = 2)
REQ-028 Release reset, hold load = 0 -> anode 1111 for 2 cycles, then 1110 for 8, 1111 for 2, 1101 for 8, and so on; frame_done pulses every 40 cycles; digit_code = 0.
REQ-029 Pulse load with value_in = 16'h1234 mid-frame -> shadow unchanged until the wrap; next frame shows digit_code 4, 3, 2, 1 for digit_sel 0..3.
REQ-030 Load 16'hAAAA, then 16'h5555 before the wrap -> only 16'h5555 is displayed after the wrap.
REQ-031 Load 16'h00F7 on the exact wrap cycle -> digit 0 of the new frame shows 7 immediately; pending_valid = 0.
REQ-032 lz_en = 1 with shadow = 16'h0005 -> anode 1110 in digit-0 SHOW; anode stays 1111 for digits 1-3. Shadow = 16'h0000 -> only digit 0 is lit, showing 0.
REQ-033 Assert rst_n = 0 during digit 2 SHOW -> same-cycle anode 1111, digit_sel 0; after release, the REQ-028 sequence restarts.
